// File: rtl/mips32_mem_responder_if.sv
// rtl/mips32_mem_responder_if.sv - request/response handshake bundle between pipeline memory port and responder
interface mips32_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mips32_mem_responder.sv
// rtl/mips32_mem_responder.sv - single-outstanding word memory responder with programmable wait states (option: MIPS_MEM_RANGE_CHECK_EN)
module mips32_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mips32_mem_responder_if.slave bus
);
   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        wr_en;
   logic        in_range;
   logic [AW-1:0] idx;

   logic [31:0] mem_q [DEPTH];

   // Without range checking the upper address bits simply wrap onto the array.
   assign idx = bus.req_addr[AW-1:0];

`ifdef MIPS_MEM_RANGE_CHECK_EN
   assign in_range = (bus.req_addr < 32'(DEPTH));
`else
   logic unused_addr_hi;
   assign in_range       = 1'b1;
   assign unused_addr_hi = ^bus.req_addr[31:AW];
`endif

   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   // Next-state, handshake outputs and accept-time capture of response data.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      wr_en         = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               wr_en   = bus.req_we && in_range;
               rdata_d = (!bus.req_we && in_range) ? mem_q[idx] : 32'h0;
               err_d   = !in_range;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
               cnt_d   = 4'd0;
            end
         end
         S_RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage array; writes commit on the accept edge and are never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[idx] <= bus.req_wdata;
      end
   end
endmodule
